nibble_serial_subtractor: RTL and testbench
===========================================

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a subtraction; sampled only while ready=1.
REQ-005 a  input  WIDTH  minuend, captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend, captured on the accepting edge.
REQ-007 ready  output  1  high only in IDLE; a new start is accepted only when ready=1.
REQ-008 done  output  1  one-cycle pulse marking diff/borrow_out/overflow valid.
REQ-009 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 borrow_out  output  1  1 when unsigned a < b.
REQ-011 overflow  output  1  1 when the two's-complement result of a - b is not representable in WIDTH bits.

Function
REQ-012 Datapath SHALL be one 4-bit slice computing a_nib + ~b_nib + carry, using generate/propagate carry lookahead inside the slice; no WIDTH-wide adder.
REQ-013 States: IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE: ready=1; start=1 on an edge SHALL latch a, b, set the carry register to 1, set the nibble counter to 0, and move to RUN.
REQ-015 RUN: each edge SHALL process nibble index k (bits 4k+3..4k, LSB nibble first), write the result into diff[4k+3:4k], store the slice carry-out into the carry register, and increment k.
REQ-016 RUN SHALL last exactly WIDTH/4 edges; the edge processing the last nibble moves to DONE.
REQ-017 DONE: done=1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle after the (WIDTH/4+1)th rising edge, counting the start-accepting edge as edge 1 (5 edges for WIDTH=16).
REQ-019 borrow_out SHALL equal the inverse of the final slice carry-out.
REQ-020 overflow SHALL equal (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]), using the latched operands.
REQ-021 diff, borrow_out and overflow SHALL hold their values from done until the next accepted start; the contents of diff during RUN are not specified.
REQ-022 start while in RUN or DONE SHALL be ignored and SHALL NOT queue; a and b changing after acceptance SHALL NOT affect the result.
REQ-023 start held high continuously SHALL start a new operation on the first IDLE edge after each DONE, so back-to-back throughput is one result per WIDTH/4+2 cycles.

Reset
REQ-024 rst=1 on an edge SHALL force IDLE and set ready=1, done=0, diff=0, borrow_out=0, overflow=0, carry register=0 and nibble counter=0, regardless of start.
REQ-025 rst asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-026 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=16: a=0x1234, b=0x0034, one-cycle start -> ready=0 for 5 cycles; done pulses once; diff=0x1200, borrow_out=0, overflow=0.
REQ-028 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow_out=1, overflow=0; a=0x8000, b=0x0001 -> diff=0x7FFF, borrow_out=0, overflow=1.
REQ-029 a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow_out=1, overflow=1; a=b=0xABCD -> diff=0x0000, borrow_out=0, overflow=0.
REQ-030 Pulse start again and change a/b during RUN -> no effect; result matches the first operands; exactly one done pulse.
REQ-031 Assert rst on the 2nd RUN cycle -> the next cycle shows ready=1, done=0, diff=0; no done pulse follows; a new start then gives the correct result.
REQ-032 Hold start=1 with 1000 random operand pairs against a golden model of a-b -> every done matches diff, borrow_out and overflow, with a done spacing of 6 cycles.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: one 4-bit lookahead slice walks the operands LSB nibble first,
// producing a - b plus borrow and signed-overflow flags after WIDTH/4 slice steps.
module nibble_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(NIB);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [CW+1:0]    idx;
   logic             last;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       g;
   logic [3:0]       p;
   logic [4:0]       c;
   logic [3:0]       sum;

   // Slice adds a + ~b + carry; carry-in of 1 on the first nibble completes the two's complement.
   always_comb begin
      idx   = {cnt, 2'b00};
      last  = (cnt == CW'(NIB - 1));
      a_nib = a_reg[idx +: 4];
      b_nib = ~b_reg[idx +: 4];
      g     = a_nib & b_nib;
      p     = a_nib ^ b_nib;
      c[0]  = carry;
      c[1]  = g[0] | (p[0] & c[0]);
      c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum   = p ^ c[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_next = RUN;
         end
         RUN: begin
            if (last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Flags are taken from the final slice, so they appear together with done.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= a;
                  b_reg <= b;
                  carry <= 1'b1;
                  cnt   <= '0;
               end
            end
            RUN: begin
               diff[idx +: 4] <= sum;
               carry          <= c[4];
               cnt            <= last ? '0 : cnt + 1'b1;
               if (last) begin
                  borrow_out <= ~c[4];
                  overflow   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (sum[3] != a_reg[WIDTH-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor (WIDTH=16): directed vectors, reset abort and a
// back-to-back randomized run, all checked against plain-arithmetic expectations.
module tb_nibble_serial_subtractor;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        ready;
   logic        done;
   logic [15:0] diff;
   logic        borrow_out;
   logic        overflow;

   int vectors;
   int miscompares;
   int cyc;

   nibble_serial_subtractor #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .ready      (ready),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned wraparound for diff, unsigned compare for borrow,
   // signed integer range check for overflow.
   task automatic checkOutput(input string tag, input logic [15:0] ta, input logic [15:0] tb_op);
      logic [15:0] exp_diff;
      logic        exp_borrow;
      logic        exp_ovf;
      int          sd;
      exp_diff   = 16'((32'(ta) + 32'h10000 - 32'(tb_op)) % 32'h10000);
      exp_borrow = (ta < tb_op);
      sd         = int'($signed(ta)) - int'($signed(tb_op));
      exp_ovf    = (sd > 32767) || (sd < -32768);
      compare({tag, "_diff"},     32'(diff),       32'(exp_diff));
      compare({tag, "_borrow"},   32'(borrow_out), 32'(exp_borrow));
      compare({tag, "_overflow"}, 32'(overflow),   32'(exp_ovf));
   endtask

   // Called at a negedge in IDLE; one-cycle start, optional start pulse and operand churn during RUN.
   task automatic applyStimulus(input string tag, input logic [15:0] ta, input logic [15:0] tb_op,
                                input bit disturb);
      int lat;
      int ready_low;
      start = 1'b1;
      a     = ta;
      b     = tb_op;
      @(negedge clk);
      lat       = 1;
      ready_low = (ready === 1'b0) ? 1 : 0;
      if (disturb) begin
         a = ~ta;
         b = $urandom;
      end else begin
         start = 1'b0;
      end
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         start = 1'b0;
         if (disturb) begin
            a = $urandom;
            b = $urandom;
         end
         lat++;
         if (ready === 1'b0) ready_low++;
      end
      compare({tag, "_done_seen"}, 32'(done), 32'd1);
      compare({tag, "_latency"}, 32'(lat), 32'd5);
      compare({tag, "_ready_low"}, 32'(ready_low), 32'd5);
      checkOutput(tag, ta, tb_op);
      @(negedge clk);
      compare({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      compare({tag, "_ready_back"}, 32'(ready), 32'd1);
      checkOutput({tag, "_hold"}, ta, tb_op);
   endtask

   initial begin
      logic [15:0] ta;
      logic [15:0] tb_op;
      int          lat;
      int          wait_cnt;
      int          prev_done;
      int          done_count;

      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      rst         = 1'b1;
      start       = 1'b1;
      a           = 16'hFFFF;
      b           = 16'h0001;
      repeat (2) @(negedge clk);
      compare("reset_ready", 32'(ready), 32'd1);
      compare("reset_done", 32'(done), 32'd0);
      compare("reset_diff", 32'(diff), 32'd0);
      compare("reset_borrow", 32'(borrow_out), 32'd0);
      compare("reset_overflow", 32'(overflow), 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);

      applyStimulus("d1234", 16'h1234, 16'h0034, 1'b0);
      compare("d1234_exact", 32'(diff), 32'h1200);
      applyStimulus("zero_minus_one", 16'h0000, 16'h0001, 1'b0);
      applyStimulus("min_minus_one", 16'h8000, 16'h0001, 1'b0);
      applyStimulus("max_minus_neg1", 16'h7FFF, 16'hFFFF, 1'b0);
      compare("max_minus_neg1_exact", 32'(diff), 32'h8000);
      applyStimulus("equal", 16'hABCD, 16'hABCD, 1'b0);
      applyStimulus("disturb", 16'h3C5A, 16'h9E17, 1'b1);

      // Abort on the second RUN cycle.
      start = 1'b1;
      a     = 16'h5555;
      b     = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      compare("abort_ready", 32'(ready), 32'd1);
      compare("abort_done", 32'(done), 32'd0);
      compare("abort_diff", 32'(diff), 32'd0);
      compare("abort_borrow", 32'(borrow_out), 32'd0);
      compare("abort_overflow", 32'(overflow), 32'd0);
      done_count = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) done_count++;
      end
      compare("abort_no_done", 32'(done_count), 32'd0);
      applyStimulus("after_abort", 16'h0F0F, 16'hF0F1, 1'b0);

      // Back-to-back with start held high and operands churning outside IDLE.
      $display("[TB] random back-to-back phase");
      start     = 1'b1;
      prev_done = -1;
      for (int n = 0; n < 1000; n++) begin
         wait_cnt = 0;
         while (ready !== 1'b1 && wait_cnt < 20) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            wait_cnt++;
         end
         compare("rnd_ready", 32'(ready), 32'd1);
         if (ready !== 1'b1) break;
         ta    = 16'($urandom);
         tb_op = 16'($urandom);
         a     = ta;
         b     = tb_op;
         @(negedge clk);
         lat = 1;
         while (done !== 1'b1 && lat < 20) begin
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            lat++;
         end
         compare("rnd_done", 32'(done), 32'd1);
         if (done !== 1'b1) break;
         checkOutput("rnd", ta, tb_op);
         if (prev_done >= 0) compare("rnd_spacing", 32'(cyc - prev_done), 32'd6);
         prev_done = cyc;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
